// File: rtl/tournament_update_ctrl_pkg.sv
// Shared types and encodings for the tournament predictor update controller.
package tournament_update_ctrl_pkg;

    // Update sequencer states: one table write per UPD state.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StUpdG = 2'b01,
        StUpdL = 2'b10,
        StUpdC = 2'b11
    } upd_state_e;

    // Table select encodings driven on upd_sel_o.
    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_GLOBAL = 2'b01;
    localparam logic [1:0] SEL_LOCAL  = 2'b10;
    localparam logic [1:0] SEL_CHOICE = 2'b11;

    // Choice counter MSB selects the global table, otherwise the local table.
    function automatic logic choose_pred(input logic gp, input logic lp, input logic [1:0] cp);
        return cp[1] ? gp : lp;
    endfunction

endpackage

// File: rtl/tournament_update_ctrl_if.sv
// Request, resolution and table-update signals of the tournament update controller.
interface tournament_update_ctrl_if #(
    parameter int unsigned bht_idx_width_p = 10,
    parameter int unsigned ghist_width_p   = 12
);
    // Prediction request side
    logic                       r_v_i;
    logic [bht_idx_width_p-1:0] idx_r_i;
    logic                       gp_i;
    logic                       lp_i;
    logic [1:0]                 cp_i;
    logic                       predict_o;
    logic                       r_ready_o;

    // Resolution side
    logic                       w_v_i;
    logic [bht_idx_width_p-1:0] idx_w_i;
    logic                       correct_i;
    logic                       w_ready_o;

    // Table update side
    logic                       upd_v_o;
    logic [1:0]                 upd_sel_o;
    logic [bht_idx_width_p-1:0] upd_idx_o;
    logic                       upd_taken_o;
    logic                       upd_inc_o;
    logic [ghist_width_p-1:0]   ghist_o;
    logic                       err_o;

    modport master (
        output r_v_i, idx_r_i, gp_i, lp_i, cp_i, w_v_i, idx_w_i, correct_i,
        input  predict_o, r_ready_o, w_ready_o, upd_v_o, upd_sel_o, upd_idx_o,
        input  upd_taken_o, upd_inc_o, ghist_o, err_o
    );

    modport slave (
        input  r_v_i, idx_r_i, gp_i, lp_i, cp_i, w_v_i, idx_w_i, correct_i,
        output predict_o, r_ready_o, w_ready_o, upd_v_o, upd_sel_o, upd_idx_o,
        output upd_taken_o, upd_inc_o, ghist_o, err_o
    );

endinterface

// File: rtl/tournament_inflight_fifo.sv
// In-flight prediction queue: circular buffer with push, pop and whole-queue flush.
module tournament_inflight_fifo #(
    parameter int unsigned width_p = 13,
    parameter int unsigned depth_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned PtrW = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int unsigned CntW = $clog2(depth_p) + 1;

    logic [width_p-1:0] mem_q [depth_p];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count_q == CntW'(depth_p));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Flush wins over a same-cycle push so nothing survives a flush.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // Next pointer and occupancy; power-of-two depth makes pointer wrap free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tournament_update_ctrl.sv
// Tournament predictor update controller: queues predictions, resolves them in order and
// sequences the global/local/choice table writes plus the global history shift.
module tournament_update_ctrl
    import tournament_update_ctrl_pkg::*;
#(
    parameter int unsigned bht_idx_width_p = 10,
    parameter int unsigned ghist_width_p   = 12,
    parameter int unsigned inflight_p      = 4
) (
    input logic                    clk_i,
    input logic                    reset_n_i,
    tournament_update_ctrl_if.slave bus
);

    typedef struct packed {
        logic [bht_idx_width_p-1:0] idx;
        logic                       gp;
        logic                       lp;
        logic                       pred;
    } entry_t;

    localparam int unsigned EntryW = bht_idx_width_p + 3;

    upd_state_e                 state_q, state_d;
    logic [bht_idx_width_p-1:0] idx_q;
    logic                       taken_q;
    logic                       gp_q;
    logic                       lp_q;
    logic [ghist_width_p-1:0]   ghist_q;
    logic                       err_q;

    entry_t      push_entry;
    logic [EntryW-1:0] head_bits;
    entry_t      head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        predict;
    logic        push;
    logic        w_ready;
    logic        accept;
    logic        good;
    logic        bad;
    logic        taken_new;
    logic        upd_v;
    logic [1:0]  upd_sel;
    logic        upd_inc;

    assign predict  = bus.r_v_i && choose_pred(bus.gp_i, bus.lp_i, bus.cp_i);
    assign push     = bus.r_v_i && !fifo_full;
    assign w_ready  = (state_q == StIdle) && !fifo_empty;
    assign accept   = bus.w_v_i && w_ready;
    assign head     = entry_t'(head_bits);
    assign good     = accept && (bus.idx_w_i == head.idx);
    assign bad      = accept && (bus.idx_w_i != head.idx);
    // Actual outcome: the stored prediction, inverted when it was wrong.
    assign taken_new = head.pred ^ ~bus.correct_i;

    assign push_entry.idx  = bus.idx_r_i;
    assign push_entry.gp   = bus.gp_i;
    assign push_entry.lp   = bus.lp_i;
    assign push_entry.pred = predict;

    tournament_inflight_fifo #(
        .width_p (EntryW),
        .depth_p (inflight_p)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .pop_i     (good),
        .flush_i   (bad),
        .data_i    (push_entry),
        .data_o    (head_bits),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Next state and per-state table write strobes.
    always_comb begin
        state_d = state_q;
        upd_v   = 1'b0;
        upd_sel = SEL_NONE;
        upd_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (good) begin
                    state_d = StUpdG;
                end
            end
            StUpdG: begin
                upd_v   = 1'b1;
                upd_sel = SEL_GLOBAL;
                state_d = StUpdL;
            end
            StUpdL: begin
                upd_v   = 1'b1;
                upd_sel = SEL_LOCAL;
                // Choice counter only trains when the two tables disagreed.
                state_d = (gp_q != lp_q) ? StUpdC : StIdle;
            end
            StUpdC: begin
                upd_v   = 1'b1;
                upd_sel = SEL_CHOICE;
                upd_inc = (gp_q == taken_q);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the resolved entry for the update sequence; shift history leaving UPD_G.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_q   <= '0;
            taken_q <= 1'b0;
            gp_q    <= 1'b0;
            lp_q    <= 1'b0;
            ghist_q <= '0;
        end else begin
            if (good) begin
                idx_q   <= head.idx;
                taken_q <= taken_new;
                gp_q    <= head.gp;
                lp_q    <= head.lp;
            end
            if (state_q == StUpdG) begin
                ghist_q <= {ghist_q[ghist_width_p-2:0], taken_q};
            end
        end
    end

    // Protocol error pulse: resolution while not ready, or index mismatch at the head.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (bus.w_v_i && !w_ready) || bad;
        end
    end

    assign bus.predict_o   = predict;
    assign bus.r_ready_o   = !fifo_full;
    assign bus.w_ready_o   = w_ready;
    assign bus.upd_v_o     = upd_v;
    assign bus.upd_sel_o   = upd_sel;
    assign bus.upd_idx_o   = upd_v ? idx_q : '0;
    assign bus.upd_taken_o = upd_v && taken_q;
    assign bus.upd_inc_o   = upd_inc;
    assign bus.ghist_o     = ghist_q;
    assign bus.err_o       = err_q;

endmodule
